// File: rtl/grom_io_pkg.sv
// Shared address map and channel state encoding for the GROM I/O controller.
package grom_io_pkg;

  localparam logic [3:0] ADDR_OUT_BASE = 4'h0;
  localparam logic [3:0] ADDR_IN_BASE  = 4'h8;
  localparam logic [3:0] ADDR_MASK     = 4'hC;
  localparam logic [3:0] ADDR_STATUS   = 4'hD;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_ACK  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/grom_io_in_channel.sv
// One input channel: in_valid synchroniser, 4-phase handshake FSM, holding
// register and pending flag.
module grom_io_in_channel
  import grom_io_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  input  logic                  clr_i,
  output logic                  ack_o,
  output logic                  pending_o,
  output logic [DATA_WIDTH-1:0] hold_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  ch_state_e              state_q;
  logic                   ack_q;
  logic                   pending_q;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic                   sync_valid;

  assign sync_valid = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      state_q   <= CH_IDLE;
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_valid_i};
      if (clr_i) pending_q <= 1'b0;
      case (state_q)
        CH_IDLE: begin
          // A capture only happens with pending already clear, so letting it
          // override a same-edge clear never loses data.
          if (sync_valid && !pending_q) begin
            hold_q    <= in_data_i;
            pending_q <= 1'b1;
            ack_q     <= 1'b1;
            state_q   <= CH_ACK;
          end
        end
        CH_ACK: begin
          if (!sync_valid) begin
            ack_q   <= 1'b0;
            state_q <= CH_IDLE;
          end
        end
        default: state_q <= CH_IDLE;
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign pending_o = pending_q;
  assign hold_o    = hold_q;

endmodule

// File: rtl/grom_io_controller.sv
// CPU-mapped I/O block: write-strobed output ports, handshaked input channels
// with pending/mask interrupt logic and registered read data.
module grom_io_controller
  import grom_io_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_OUT     = 4,
  parameter int NUM_IN      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          we,
  input  logic                          ioreq,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_ports,
  output logic [NUM_OUT-1:0]            out_strobe,
  input  logic [NUM_IN*DATA_WIDTH-1:0]  in_ports,
  input  logic [NUM_IN-1:0]             in_valid,
  output logic [NUM_IN-1:0]             in_ack,
  output logic                          irq
);

  logic [3:0]                    a;
  logic                          wr;
  logic                          rd;
  logic                          unused_addr;
  logic [NUM_OUT*DATA_WIDTH-1:0] out_q, out_d;
  logic [NUM_OUT-1:0]            strobe_q, strobe_d;
  logic [NUM_IN-1:0]             mask_q, mask_d;
  logic [NUM_IN-1:0]             clr;
  logic [NUM_IN-1:0]             pending;
  logic [NUM_IN*DATA_WIDTH-1:0]  hold;
  logic [DATA_WIDTH-1:0]         rd_q, rd_d, rd_mux;
  logic                          irq_q;

  assign a           = addr[3:0];
  assign wr          = ioreq & we;
  assign rd          = ioreq & ~we;
  assign unused_addr = ^addr[ADDR_WIDTH-1:4];

  always_comb begin
    out_d    = out_q;
    strobe_d = '0;
    mask_d   = mask_q;
    clr      = '0;
    rd_mux   = '0;
    rd_d     = rd_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (a == ADDR_OUT_BASE + 4'(k)) begin
        rd_mux = out_q[k*DATA_WIDTH +: DATA_WIDTH];
        if (wr) begin
          out_d[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
          strobe_d[k]                       = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (a == ADDR_IN_BASE + 4'(i)) begin
        rd_mux = hold[i*DATA_WIDTH +: DATA_WIDTH];
        if (rd) clr[i] = 1'b1;
      end
    end
    if (a == ADDR_MASK) begin
      rd_mux[NUM_IN-1:0] = mask_q;
      if (wr) mask_d = data_in[NUM_IN-1:0];
    end
    if (a == ADDR_STATUS) begin
      rd_mux[NUM_IN-1:0] = pending;
      if (wr) clr = clr | data_in[NUM_IN-1:0];
    end
    if (rd) rd_d = rd_mux;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q    <= '0;
      strobe_q <= '0;
      mask_q   <= '0;
      rd_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      strobe_q <= strobe_d;
      mask_q   <= mask_d;
      rd_q     <= rd_d;
      irq_q    <= |(pending & mask_q);
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    grom_io_in_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .in_data_i (in_ports[i*DATA_WIDTH +: DATA_WIDTH]),
      .in_valid_i(in_valid[i]),
      .clr_i     (clr[i]),
      .ack_o     (in_ack[i]),
      .pending_o (pending[i]),
      .hold_o    (hold[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign out_ports  = out_q;
  assign out_strobe = strobe_q;
  assign rd_data    = rd_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_grom_io_controller.sv
// Scoreboard bench for grom_io_controller: directed scenarios followed by
// randomized CPU traffic and producers, checked against a behavioural model.
module tb_grom_io_controller;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int NO = 4;
  localparam int NI = 2;
  localparam int S  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [DW-1:0]   data_in = '0;
  logic            we = 1'b0;
  logic            ioreq = 1'b0;
  logic [DW-1:0]   rd_data;
  logic [NO*DW-1:0] out_ports;
  logic [NO-1:0]   out_strobe;
  logic [NI*DW-1:0] in_ports = '0;
  logic [NI-1:0]   in_valid = '0;
  logic [NI-1:0]   in_ack;
  logic            irq;

  grom_io_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OUT(NO), .NUM_IN(NI), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we),
    .ioreq(ioreq), .rd_data(rd_data), .out_ports(out_ports),
    .out_strobe(out_strobe), .in_ports(in_ports), .in_valid(in_valid),
    .in_ack(in_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] mport [NO];
  logic [DW-1:0] mhold [NI];
  logic [NO-1:0] mstrobe = '0;
  logic [NI-1:0] mpend = '0;
  logic [NI-1:0] mmask = '0;
  logic [NI-1:0] mack = '0;
  logic          mirq = 1'b0;
  logic [NI-1:0] vlog [64];
  int            n_edge = 0;
  int            rel_edge = 0;
  logic          rd_flag = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [DW-1:0] exp_q [$];
  chk_t          chk_q [$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] last_rd = '0;

  initial begin
    for (int k = 0; k < NO; k++) mport[k] = '0;
    for (int i = 0; i < NI; i++) mhold[i] = '0;
    for (int j = 0; j < 64; j++) vlog[j] = '0;
  end

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ad);
    int a;
    a = int'(ad[3:0]);
    if (a < 8)  return (a < NO) ? mport[a] : '0;
    if (a < 12) return (a - 8 < NI) ? mhold[a-8] : '0;
    if (a == 12) return DW'(mmask);
    if (a == 13) return DW'(mpend);
    return '0;
  endfunction

  function automatic logic [NO*DW-1:0] exp_out();
    logic [NO*DW-1:0] v;
    for (int k = 0; k < NO; k++) v[k*DW +: DW] = mport[k];
    return v;
  endfunction

  // Model advances on the same edge as the DUT; sync_valid is in_valid as
  // sampled S edges earlier, counting only edges since the last reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NO; k++) mport[k] = '0;
      for (int i = 0; i < NI; i++) mhold[i] = '0;
      mstrobe = '0; mpend = '0; mmask = '0; mack = '0; mirq = 1'b0;
      rd_flag = 1'b0; last_rd = '0; rel_edge = n_edge;
      exp_q.delete();
    end else begin
      logic          nirq;
      logic [NI-1:0] clrv;
      int            a;
      logic          sv;
      nirq    = |(mpend & mmask);
      clrv    = '0;
      mstrobe = '0;
      rd_flag = ioreq && !we;
      a       = int'(addr[3:0]);
      if (ioreq && we) begin
        if (a < NO) begin mport[a] = data_in; mstrobe[a] = 1'b1; end
        else if (a == 12) mmask = data_in[NI-1:0];
        else if (a == 13) clrv = data_in[NI-1:0];
      end else if (ioreq && a >= 8 && a < 8 + NI) begin
        clrv[a-8] = 1'b1;
      end
      for (int i = 0; i < NI; i++) begin
        sv = (n_edge - S >= rel_edge) ? vlog[(n_edge - S) % 64][i] : 1'b0;
        if (!mack[i]) begin
          if (sv && !mpend[i]) begin
            mhold[i] = in_ports[i*DW +: DW];
            mpend[i] = 1'b1;
            mack[i]  = 1'b1;
          end else if (clrv[i]) mpend[i] = 1'b0;
        end else begin
          if (clrv[i]) mpend[i] = 1'b0;
          if (!sv) mack[i] = 1'b0;
        end
      end
      vlog[n_edge % 64] = in_valid;
      n_edge++;
      mirq = nirq;
    end
  end

  // Monitor: per-cycle output checks, read scoreboard and posted checks.
  always @(negedge clk) begin
    chk_t c;
    tests += 4;
    if (out_ports !== exp_out()) begin
      fails++; $display("FAIL out_ports actual=%0h required=%0h", out_ports, exp_out());
    end
    if (out_strobe !== mstrobe) begin
      fails++; $display("FAIL out_strobe actual=%0b required=%0b", out_strobe, mstrobe);
    end
    if (in_ack !== mack) begin
      fails++; $display("FAIL in_ack actual=%0b required=%0b", in_ack, mack);
    end
    if (irq !== mirq) begin
      fails++; $display("FAIL irq actual=%0b required=%0b", irq, mirq);
    end
    tests++;
    if (rd_flag) begin
      if (exp_q.size() == 0) begin
        fails++; $display("FAIL rd_underflow actual=%0h required=none", rd_data);
      end else begin
        last_rd = exp_q.pop_front();
        if (rd_data !== last_rd) begin
          fails++; $display("FAIL rd_data actual=%0h required=%0h", rd_data, last_rd);
        end
      end
    end else if (rd_data !== last_rd) begin
      fails++; $display("FAIL rd_hold actual=%0h required=%0h", rd_data, last_rd);
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      tests++;
      if (c.act !== c.exp) begin
        fails++; $display("FAIL %s actual=%0h required=%0h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    ioreq = 1'b1; we = w; addr = ad; data_in = d;
    if (!w) exp_q.push_back(model_read(ad));
    tick();
    ioreq = 1'b0; we = 1'b0;
  endtask

  task automatic wait_ack(input int ch, input logic v);
    int cnt;
    cnt = 0;
    while (in_ack[ch] !== v && cnt < 30) begin
      tick();
      cnt++;
    end
    post("ack_wait", 32'(in_ack[ch]), 32'(v));
  endtask

  initial begin
    repeat (3) tick();
    post("reset_rd", 32'(rd_data), 32'h0);
    post("reset_out", out_ports, 32'h0);
    post("reset_ack", 32'(in_ack), 32'h0);
    reset = 1'b1;
    tick();

    // Output port write and strobe
    cpu(1'b1, 12'h002, 8'h5A);
    post("wr_port2", out_ports, 32'h005A0000);
    post("wr_strobe", 32'(out_strobe), 32'h4);
    tick();
    post("strobe_1cyc", 32'(out_strobe), 32'h0);

    // Handshake timing, status, irq and holding-register read
    cpu(1'b1, 12'h00C, 8'h01);
    in_ports[7:0] = 8'h3C; in_valid[0] = 1'b1;
    repeat (S) tick();
    post("ack_early", 32'(in_ack[0]), 32'h0);
    tick();
    post("ack_rise", 32'(in_ack[0]), 32'h1);
    cpu(1'b0, 12'h00D, 8'h00);
    post("status", 32'(rd_data), 32'h01);
    post("irq_set", 32'(irq), 32'h1);
    in_valid[0] = 1'b0;
    repeat (S) tick();
    post("ack_hold", 32'(in_ack[0]), 32'h1);
    tick();
    post("ack_fall", 32'(in_ack[0]), 32'h0);
    cpu(1'b0, 12'h008, 8'h00);
    post("hold_rd", 32'(rd_data), 32'h3C);
    post("irq_lag", 32'(irq), 32'h1);
    tick();
    post("irq_clr", 32'(irq), 32'h0);

    // Request blocked while pending is set
    in_ports[7:0] = 8'h11; in_valid[0] = 1'b1;
    wait_ack(0, 1'b1);
    in_valid[0] = 1'b0;
    wait_ack(0, 1'b0);
    in_ports[7:0] = 8'h22; in_valid[0] = 1'b1;
    repeat (8) tick();
    post("blocked", 32'(in_ack[0]), 32'h0);
    cpu(1'b1, 12'h00D, 8'h01);
    wait_ack(0, 1'b1);
    in_valid[0] = 1'b0;
    wait_ack(0, 1'b0);
    cpu(1'b0, 12'h008, 8'h00);
    post("recapture", 32'(rd_data), 32'h22);

    // Unimplemented port and upper-address aliasing
    cpu(1'b0, 12'hF35, 8'h00);
    post("unimpl_rd", 32'(rd_data), 32'h0);
    cpu(1'b1, 12'hF35, 8'h77);
    post("unimpl_wr", out_ports, 32'h005A0000);
    cpu(1'b0, 12'h102, 8'h00);
    post("alias_rd", 32'(rd_data), 32'h5A);
    cpu(1'b1, 12'h102, 8'h99);
    post("alias_wr", out_ports, 32'h00990000);

    // Reset in the middle of a handshake
    in_ports[7:0] = 8'h44; in_valid[0] = 1'b1;
    wait_ack(0, 1'b1);
    repeat (2) tick();
    post("irq_pre_rst", 32'(irq), 32'h1);
    reset = 1'b0;
    #1;
    post("rst_ack", 32'(in_ack), 32'h0);
    post("rst_irq", 32'(irq), 32'h0);
    post("rst_out", out_ports, 32'h0);
    tick(); tick();
    reset = 1'b1;
    wait_ack(0, 1'b1);
    cpu(1'b0, 12'h008, 8'h00);
    post("fresh_cap", 32'(rd_data), 32'h44);
    in_valid[0] = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (!in_valid[i] && !in_ack[i] && $urandom_range(0, 3) == 0) begin
          in_ports[i*DW +: DW] = DW'($urandom);
          in_valid[i] = 1'b1;
        end else if (in_valid[i] && in_ack[i] && $urandom_range(0, 1) == 0) begin
          in_valid[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        cpu(1'($urandom), AW'($urandom), DW'($urandom));
      end else begin
        tick();
      end
    end

    in_valid = '0;
    repeat (10) tick();
    post("sb_drain", 32'(exp_q.size()), 32'h0);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
